// File: rtl/mmio_counter_ctrl_if.sv
// MMIO request/response bundle for the event counter block.
// master drives requests, slave returns data and a one-cycle response.
interface mmio_counter_ctrl_if;
    logic        MMIO_read;
    logic        MMIO_write;
    logic [3:0]  counter_address;
    logic [15:0] mmio_wdata;
    logic [15:0] mmio_rdata;
    logic        mmio_resp;

    modport master (
        output MMIO_read, MMIO_write, counter_address, mmio_wdata,
        input  mmio_rdata, mmio_resp
    );

    modport slave (
        input  MMIO_read, MMIO_write, counter_address, mmio_wdata,
        output mmio_rdata, mmio_resp
    );
endinterface

// File: rtl/mmio_counter_ctrl.sv
// Eight 16-bit event counters behind a 3-cycle MMIO port.
// Define MMIO_OVF_IRQ_EN for the masked, registered overflow interrupt.
module mmio_counter_ctrl (
    input  logic                     clk,
    input  logic                     reset_n,
    mmio_counter_ctrl_if.slave       bus,
    input  logic [7:0]               event_in,
    output logic                     ovf_irq
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

`ifdef MMIO_OVF_IRQ_EN
    localparam logic [15:0] CTRL_MASK = 16'hFFFF;
`else
    localparam logic [15:0] CTRL_MASK = 16'h00FF;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_addr;
    logic [15:0] r_wdata;
    logic        r_wr;
    logic        r_rd;
    logic [15:0] r_cnt [8];
    logic [15:0] r_ctrl;
    logic [7:0]  r_ovf;
    logic [15:0] r_rdata;

    logic        w_commit;
    logic [7:0]  w_clr;
    logic [7:0]  w_w1c;
    logic [7:0]  w_set;
    logic [15:0] w_cnt_nxt [8];
    logic [15:0] w_rd_val;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.MMIO_read || bus.MMIO_write) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_commit = (r_state == ACCESS) && r_wr;
    assign w_clr = (w_commit && r_addr == 4'h9) ? r_wdata[7:0] : 8'h00;
    assign w_w1c = (w_commit && r_addr == 4'hA) ? r_wdata[7:0] : 8'h00;

    // CLEAR beats a direct write, which beats an increment.
    always_comb begin
        w_set = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_clr[i]) begin
                w_cnt_nxt[i] = 16'h0000;
            end else if (w_commit && r_addr == 4'(i)) begin
                w_cnt_nxt[i] = r_wdata;
            end else if (event_in[i] && r_ctrl[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + 16'd1;
                w_set[i]     = &r_cnt[i];
            end
        end
    end

    always_comb begin
        w_rd_val = 16'h0000;
        if (!r_addr[3]) w_rd_val = r_cnt[r_addr[2:0]];
        else if (r_addr == 4'h8) w_rd_val = r_ctrl;
        else if (r_addr == 4'hA) w_rd_val = {8'h00, r_ovf};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_addr  <= 4'h0;
            r_wdata <= 16'h0000;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_ctrl  <= 16'h0000;
            r_ovf   <= 8'h00;
            r_rdata <= 16'h0000;
            for (int i = 0; i < 8; i++) r_cnt[i] <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && (bus.MMIO_read || bus.MMIO_write)) begin
                r_addr  <= bus.counter_address;
                r_wdata <= bus.mmio_wdata;
                r_wr    <= bus.MMIO_write;
                r_rd    <= bus.MMIO_read && !bus.MMIO_write;
            end
            if (r_state == ACCESS) begin
                r_rdata <= r_rd ? w_rd_val : 16'h0000;
            end
            if (w_commit && r_addr == 4'h8) begin
                r_ctrl <= r_wdata & CTRL_MASK;
            end
            // A wrap in the W1C cycle keeps its sticky bit.
            r_ovf <= (r_ovf & ~w_w1c) | w_set;
            for (int i = 0; i < 8; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    assign bus.mmio_resp  = (r_state == RESP);
    assign bus.mmio_rdata = (r_state == RESP) ? r_rdata : 16'h0000;

`ifdef MMIO_OVF_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_irq <= 1'b0;
        else          r_irq <= |(r_ovf & r_ctrl[15:8]);
    end
    assign ovf_irq = r_irq;
`else
    assign ovf_irq = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_counter_ctrl.sv
// Directed plus random bench for mmio_counter_ctrl against a register-map model.
// Checks latency, priorities, overflow, reset abort and back-to-back reads.
module tb_mmio_counter_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] event_in;
    logic       ovf_irq;

    mmio_counter_ctrl_if bus();

    mmio_counter_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .event_in (event_in),
        .ovf_irq  (ovf_irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

`ifdef MMIO_OVF_IRQ_EN
    localparam logic [15:0] MASK = 16'hFFFF;
`else
    localparam logic [15:0] MASK = 16'h00FF;
`endif

    logic [15:0] m_cnt [8];
    logic [15:0] m_ctrl;
    logic [7:0]  m_ovf;
    logic        m_irq;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = 16'h0000;
        m_ctrl = 16'h0000;
        m_ovf  = 8'h00;
        m_irq  = 1'b0;
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] a);
        if (a < 4'h8)  return m_cnt[a[2:0]];
        if (a == 4'h8) return m_ctrl;
        if (a == 4'hA) return {8'h00, m_ovf};
        return 16'h0000;
    endfunction

    // One clock edge of the register map; wr means a write lands this edge.
    task automatic m_edge(input logic [7:0] ev, input bit wr,
                          input logic [3:0] a, input logic [15:0] d);
        logic [7:0] set = 8'h00;
        logic [7:0] w1c = 8'h00;
        m_irq = |(m_ovf & m_ctrl[15:8]);
        for (int i = 0; i < 8; i++) begin
            if (wr && a == 4'h9 && d[i]) m_cnt[i] = 16'h0000;
            else if (wr && a == 4'(i)) m_cnt[i] = d;
            else if (ev[i] && m_ctrl[i]) begin
                if (m_cnt[i] == 16'hFFFF) set[i] = 1'b1;
                m_cnt[i] = m_cnt[i] + 16'd1;
            end
        end
        if (wr && a == 4'hA) w1c = d[7:0];
        if (wr && a == 4'h8) m_ctrl = d & MASK;
        m_ovf = (m_ovf & ~w1c) | set;
    endtask

    task automatic cyc(input logic [7:0] ev, input bit wr,
                       input logic [3:0] a, input logic [15:0] d);
        event_in = ev;
        @(posedge clk);
        m_edge(ev, wr, a, d);
        @(negedge clk);
        chk("irq", {15'b0, ovf_irq}, {15'b0, m_irq});
    endtask

    task automatic access(input bit rd, input bit wr, input logic [3:0] a,
                          input logic [15:0] d, input logic [7:0] eva,
                          input logic [7:0] evb, input logic [7:0] evc,
                          output logic [15:0] got);
        logic [15:0] exp;
        bus.MMIO_read       = rd;
        bus.MMIO_write      = wr;
        bus.counter_address = a;
        bus.mmio_wdata      = d;
        cyc(eva, 1'b0, 4'h0, 16'h0);
        bus.MMIO_read       = 1'b0;
        bus.MMIO_write      = 1'b0;
        bus.counter_address = 4'($urandom);
        bus.mmio_wdata      = 16'($urandom);
        chk("resp_access", {15'b0, bus.mmio_resp}, 16'h0);
        exp = wr ? 16'h0000 : m_read(a);
        cyc(evb, wr, a, d);
        chk("resp_pulse", {15'b0, bus.mmio_resp}, 16'h1);
        chk($sformatf("rdata_a%h", a), bus.mmio_rdata, exp);
        got = bus.mmio_rdata;
        cyc(evc, 1'b0, 4'h0, 16'h0);
        chk("resp_end", {15'b0, bus.mmio_resp}, 16'h0);
        chk("rdata_idle", bus.mmio_rdata, 16'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        logic [15:0] g;
        access(1'b0, 1'b1, a, d, 8'h00, 8'h00, 8'h00, g);
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] g);
        access(1'b1, 1'b0, a, 16'h0, 8'h00, 8'h00, 8'h00, g);
    endtask

    initial begin
        logic [15:0] g;
        int pulses;
        reset_n             = 1'b0;
        bus.MMIO_read       = 1'b0;
        bus.MMIO_write      = 1'b0;
        bus.counter_address = 4'h0;
        bus.mmio_wdata      = 16'h0;
        event_in            = 8'hFF;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_resp", {15'b0, bus.mmio_resp}, 16'h0);
        chk("rst_rdata", bus.mmio_rdata, 16'h0);
        chk("rst_irq", {15'b0, ovf_irq}, 16'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 11; a++) rd(4'(a), g);

        // five enabled events on counter 0
        wr(4'h8, 16'h0001);
        repeat (5) cyc(8'h01, 1'b0, 4'h0, 16'h0);
        rd(4'h0, g);
        chk("cnt0_five", g, 16'h0005);

        // wrap sets sticky overflow and the masked interrupt
        wr(4'h2, 16'hFFFF);
        wr(4'h8, 16'h0404);
        cyc(8'h04, 1'b0, 4'h0, 16'h0);
        rd(4'hA, g);
        chk("ovf_after_wrap", g, 16'h0004);
        rd(4'h2, g);
        chk("cnt2_wrapped", g, 16'h0000);
`ifdef MMIO_OVF_IRQ_EN
        chk("irq_on", {15'b0, ovf_irq}, 16'h1);
`else
        chk("irq_off", {15'b0, ovf_irq}, 16'h0);
`endif
        wr(4'hA, 16'h0004);
        rd(4'hA, g);
        chk("ovf_cleared", g, 16'h0000);
        chk("irq_cleared", {15'b0, ovf_irq}, 16'h0);

        // same-cycle priorities on counter 1
        wr(4'h8, 16'h0002);
        access(1'b0, 1'b1, 4'h1, 16'h1234, 8'h00, 8'h02, 8'h00, g);
        rd(4'h1, g);
        chk("write_beats_inc", g, 16'h1234);
        access(1'b0, 1'b1, 4'h9, 16'h0002, 8'h00, 8'h02, 8'h00, g);
        rd(4'h1, g);
        chk("clear_beats_inc", g, 16'h0000);
        wr(4'h1, 16'hFFFF);
        access(1'b0, 1'b1, 4'h1, 16'h0005, 8'h00, 8'h02, 8'h00, g);
        rd(4'hA, g);
        chk("dropped_inc_no_ovf", g, 16'h0000);

        // reserved space and read+write collision
        rd(4'hC, g);
        chk("reserved_rd", g, 16'h0000);
        wr(4'hF, 16'hBEEF);
        access(1'b1, 1'b1, 4'h3, 16'h00C3, 8'h00, 8'h00, 8'h00, g);
        chk("rdwr_rdata", g, 16'h0000);
        for (int a = 0; a < 16; a++) rd(4'(a), g);

        // reset during the ACCESS cycle of a write
        wr(4'h0, 16'h0011);
        bus.MMIO_write      = 1'b1;
        bus.counter_address = 4'h0;
        bus.mmio_wdata      = 16'h00AA;
        cyc(8'h00, 1'b0, 4'h0, 16'h0);
        reset_n        = 1'b0;
        bus.MMIO_write = 1'b0;
        m_reset();
        #1;
        chk("abort_resp0", {15'b0, bus.mmio_resp}, 16'h0);
        event_in = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        chk("abort_resp1", {15'b0, bus.mmio_resp}, 16'h0);
        chk("abort_irq", {15'b0, ovf_irq}, 16'h0);
        reset_n = 1'b1;
        rd(4'h0, g);
        chk("abort_cnt0", g, 16'h0000);

        // request held across two accesses
        wr(4'h3, 16'h0777);
        bus.MMIO_read       = 1'b1;
        bus.counter_address = 4'h3;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(8'h00, 1'b0, 4'h0, 16'h0);
            if (k == 4) bus.MMIO_read = 1'b0;
            pulses += int'(bus.mmio_resp);
            chk($sformatf("b2b_resp%0d", k), {15'b0, bus.mmio_resp},
                (k == 1 || k == 4) ? 16'h1 : 16'h0);
            chk($sformatf("b2b_rdata%0d", k), bus.mmio_rdata,
                (k == 1 || k == 4) ? 16'h0777 : 16'h0);
        end
        cyc(8'h00, 1'b0, 4'h0, 16'h0);
        chk("b2b_tail", {15'b0, bus.mmio_resp}, 16'h0);
        chk("b2b_pulses", 16'(pulses), 16'd2);

        // random traffic against the model
        for (int n = 0; n < 80; n++) begin
            logic [3:0]  a;
            logic [15:0] d;
            int          op;
            op = int'($urandom_range(0, 9));
            a  = ($urandom_range(0, 3) == 0) ? 4'($urandom) :
                 4'($urandom_range(0, 10));
            d  = ($urandom_range(0, 2) == 0) ?
                 16'hFFFD + 16'($urandom_range(0, 2)) : 16'($urandom);
            if (op < 4)
                access(1'b1, 1'b0, a, d, 8'($urandom), 8'($urandom),
                       8'($urandom), g);
            else if (op < 8)
                access(1'b0, 1'b1, a, d, 8'($urandom), 8'($urandom),
                       8'($urandom), g);
            else if (op == 8)
                access(1'b1, 1'b1, a, d, 8'($urandom), 8'($urandom),
                       8'($urandom), g);
            else
                repeat ($urandom_range(1, 4))
                    cyc(8'($urandom), 1'b0, 4'h0, 16'h0);
        end
        for (int a = 0; a < 16; a++) rd(4'(a), g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mmio_counter_ctrl.md
MMIO_COUNTER_CTRL -- requirements
Module: mmio_counter_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge), reset_n input 1 (asynchronous, active-low).
REQ-002 SHALL have ports:
- MMIO_read, input, 1: read request, held until mmio_resp.
- MMIO_write, input, 1: write request, held until mmio_resp.
- counter_address, input, 4: register index, 0x0-0xF, mapping 0xFFF0-0xFFFF.
- mmio_wdata, input, 16: write data (lc3b_word).
- event_in, input, 8: per-counter increment strobes, one cycle each.
- mmio_rdata, output, 16: read data, valid while mmio_resp=1.
- mmio_resp, output, 1: access complete, one-cycle pulse.
- ovf_irq, output, 1: overflow interrupt (see Configuration).

Function
REQ-003 Register map SHALL be:
- 0x0-0x7: CNT0-CNT7, 16-bit, R/W.
- 0x8: CTRL, bits[7:0] per-counter enable, bits[15:8] IRQ mask, R/W.
- 0x9: CLEAR, write-1 clears the matching counter, reads 0.
- 0xA: OVF, bits[7:0] sticky overflow, write-1-to-clear, bits[15:8] read 0.
- 0xB-0xF: reserved, read 0x0000, writes ignored.
REQ-004 FSM SHALL have states IDLE, ACCESS and RESP:
- IDLE -> ACCESS when MMIO_read|MMIO_write; counter_address, mmio_wdata and the request type are latched.
- ACCESS -> RESP unconditionally; the register write commits and read data is captured.
- RESP -> IDLE unconditionally; mmio_resp=1 for exactly this cycle.
REQ-005 Access latency SHALL be 3 cycles from the request sampled in IDLE to mmio_resp; a request still asserted in the cycle after RESP SHALL start a new access.
REQ-006 MMIO_read and MMIO_write asserted together SHALL be treated as a write; mmio_rdata=0x0000.
REQ-007 mmio_rdata SHALL hold the captured value during RESP and be 0x0000 otherwise.
REQ-008 CNTn SHALL increment by 1 on each cycle with event_in[n]=1 and CTRL[n]=1; a disabled counter holds its value.
REQ-009 CNTn wrapping 0xFFFF->0x0000 SHALL set OVF[n] in the same cycle.
REQ-010 Same-cycle priority on CNTn SHALL be CLEAR write > CNT write > increment; the losing increment is dropped and sets no OVF bit.
REQ-011 Same-cycle OVF[n] set and W1C SHALL leave OVF[n]=1.
REQ-012 A read of CNTn SHALL return the value before any increment occurring in the ACCESS cycle.
REQ-013 Requests deasserted mid-access SHALL NOT abort the access; the FSM completes through RESP.

Reset
REQ-014 reset_n=0 SHALL asynchronously force state=IDLE, CNT0-7=0x0000, CTRL=0x0000, OVF=0x00, mmio_resp=0, mmio_rdata=0x0000 and ovf_irq=0.
REQ-015 Reset mid-access SHALL discard the access with no register update and no mmio_resp.
REQ-016 Event inputs during reset SHALL be ignored.

Configuration
REQ-017 With MMIO_OVF_IRQ_EN defined, ovf_irq SHALL be registered |(OVF[7:0] & CTRL[15:8]), asserting 1 cycle after the enabling condition.
REQ-018 Without MMIO_OVF_IRQ_EN, ovf_irq SHALL be constant 0, CTRL[15:8] SHALL read 0 and writes to CTRL[15:8] SHALL be ignored; OVF bits still function.

Verification
REQ-019 Write CTRL=0x0001, pulse event_in[0] 5 times, read addr 0x0 -> mmio_rdata=0x0005 with mmio_resp 3 cycles after the request.
REQ-020 Write CNT2=0xFFFF, CTRL=0x0404, pulse event_in[2] -> CNT2=0x0000 and OVF=0x0004; with MMIO_OVF_IRQ_EN, ovf_irq=1 one cycle later; write OVF=0x0004 -> OVF=0x0000 and ovf_irq=0.
REQ-021 Same cycle as the ACCESS of a write CNT1=0x1234 and event_in[1]=1 with CTRL[1]=1 -> CNT1=0x1234; the same with a CLEAR=0x0002 write -> CNT1=0x0000.
REQ-022 Read addr 0xC and write 0xF=0xBEEF -> read 0x0000, no state change, each access responds once.
REQ-023 Drop reset_n while in ACCESS of a write CNT0=0x00AA -> CNT0=0x0000, mmio_resp stays 0 and the FSM is in IDLE after reset release.
REQ-024 Hold MMIO_read across two back-to-back accesses -> mmio_resp pulses exactly twice, 3 cycles apart.
